// File: rtl/mem_access_ctrl_if.sv
// Single-port data bus between the memory access controller and the memory.
interface mem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: sequences loads/stores as single req/ack
// bus transactions, aligns store data, extracts/merges load data (big-endian
// lanes) and owns the LL/SC link bit.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_mem_addr,
  input  logic [3:0]  i_mem_sel,
  input  logic        i_bad_addr,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_rt_value,
  input  logic        i_llbit_clear,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_wb_en,
  output logic [31:0] o_wb_data,
  output logic        o_addr_exc,
  output logic        o_bus_err,
  mem_access_ctrl_if.master bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWR = 6'h2e;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR) || (op == OP_LL);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW) ||
           (op == OP_SWR) || (op == OP_SC);
  endfunction

  // Place store data on the byte lanes addressed by the offset.
  function automatic logic [31:0] store_align(input logic [5:0] op,
                                              input logic [1:0] off,
                                              input logic [31:0] rt);
    logic [4:0] sh_l;
    logic [4:0] sh_r;
    sh_l = {off, 3'b000};
    sh_r = {~off, 3'b000};
    case (op)
      OP_SB:   return {4{rt[7:0]}};
      OP_SH:   return {2{rt[15:0]}};
      OP_SWL:  return rt >> sh_l;
      OP_SWR:  return rt << sh_r;
      default: return rt;
    endcase
  endfunction

  // Extract, extend or merge read data; byte offset 0 is data[31:24].
  function automatic logic [31:0] load_align(input logic [5:0] op,
                                             input logic [1:0] off,
                                             input logic [31:0] rt,
                                             input logic [31:0] rd);
    logic [4:0]  sh_l;
    logic [4:0]  sh_r;
    logic [7:0]  b;
    logic [15:0] h;
    sh_l = {off, 3'b000};
    sh_r = {~off, 3'b000};
    b    = 8'(rd >> sh_r);
    h    = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LWL:  return (rd << sh_l) | (rt & ~(32'hffff_ffff << sh_l));
      OP_LWR:  return (rd >> sh_r) | (rt & ~(32'hffff_ffff >> sh_r));
      default: return rd;
    endcase
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [5:0]       op_q,        op_d;
  logic [1:0]       off_q,       off_d;
  logic [31:0]      rt_q,        rt_d;
  logic             link_q,      link_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             done_q,      done_d;
  logic             wb_en_q,     wb_en_d;
  logic [31:0]      wb_data_q,   wb_data_d;
  logic             addr_exc_q,  addr_exc_d;
  logic             bus_err_q,   bus_err_d;
  logic             bus_req_q,   bus_req_d;
  logic             bus_we_q,    bus_we_d;
  logic [31:0]      bus_addr_q,  bus_addr_d;
  logic [3:0]       bus_sel_q,   bus_sel_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;

  logic is_mem_in;
  assign is_mem_in = is_load(i_instr_op) || is_store(i_instr_op);

  // Stall while the bus is busy, or combinationally on acceptance in IDLE.
  assign o_stall = (state_q == S_BUSY) || ((state_q == S_IDLE) && i_valid && is_mem_in);

  // Next-state, bus sequencing, writeback and link-bit logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rt_d        = rt_q;
    link_d      = link_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    wb_en_d     = 1'b0;
    wb_data_d   = wb_data_q;
    addr_exc_d  = 1'b0;
    bus_err_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid && is_mem_in) begin
          if (i_bad_addr) begin
            state_d    = S_RESP;
            done_d     = 1'b1;
            addr_exc_d = 1'b1;
          end else if ((i_instr_op == OP_SC) && !link_q) begin
            state_d   = S_RESP;
            done_d    = 1'b1;
            wb_en_d   = 1'b1;
            wb_data_d = '0;
            link_d    = 1'b0;
          end else begin
            state_d     = S_BUSY;
            op_d        = i_instr_op;
            off_d       = i_byte_off;
            rt_d        = i_rt_value;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store(i_instr_op);
            bus_addr_d  = i_mem_addr;
            bus_sel_d   = i_mem_sel;
            bus_wdata_d = store_align(i_instr_op, i_byte_off, i_rt_value);
          end
        end
      end
      S_BUSY: begin
        if (bus.ack) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (op_q == OP_SC) begin
            wb_en_d   = 1'b1;
            wb_data_d = 32'd1;
            link_d    = 1'b0;
          end else if (is_load(op_q)) begin
            wb_en_d   = 1'b1;
            wb_data_d = load_align(op_q, off_q, rt_q, bus.rdata);
            if (op_q == OP_LL) link_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (op_q == OP_SC) link_d = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An explicit clear overrides a link set by a coincident LL ack.
    if (i_llbit_clear) link_d = 1'b0;
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      off_q       <= '0;
      rt_q        <= '0;
      link_q      <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_data_q   <= '0;
      addr_exc_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rt_q        <= rt_d;
      link_q      <= link_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_data_q   <= wb_data_d;
      addr_exc_q  <= addr_exc_d;
      bus_err_q   <= bus_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign o_done     = done_q;
  assign o_wb_en    = wb_en_q;
  assign o_wb_data  = wb_data_q;
  assign o_addr_exc = addr_exc_q;
  assign o_bus_err  = bus_err_q;
  assign bus.req    = bus_req_q;
  assign bus.we     = bus_we_q;
  assign bus.addr   = bus_addr_q;
  assign bus.sel    = bus_sel_q;
  assign bus.wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SWR = 6'h2e;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  instr_op;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic        bad_addr;
  logic [1:0]  byte_off;
  logic [31:0] rt_value;
  logic        llbit_clear;
  logic        stall, done, wb_en, addr_exc, bus_err;
  logic [31:0] wb_data;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_instr_op    (instr_op),
    .i_mem_addr    (mem_addr),
    .i_mem_sel     (mem_sel),
    .i_bad_addr    (bad_addr),
    .i_byte_off    (byte_off),
    .i_rt_value    (rt_value),
    .i_llbit_clear (llbit_clear),
    .o_stall       (stall),
    .o_done        (done),
    .o_wb_en       (wb_en),
    .o_wb_data     (wb_data),
    .o_addr_exc    (addr_exc),
    .o_bus_err     (bus_err),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] cap_we, cap_sel, cap_wdata, cap_addr;
  logic [31:0] cap_wb_en, cap_wb_data, cap_addr_exc, cap_bus_err, cap_done_after;
  int          cap_req, cap_stall, cap_done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction, acknowledge after ack_delay request cycles
  // (negative: never), and capture bus and completion outputs.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [1:0] off, input logic [31:0] rt, input logic bad,
                        input int ack_delay, input logic [31:0] rdata, input logic clr_at_ack);
    int cyc;
    logic fin;
    cap_we = 'x; cap_sel = 'x; cap_wdata = 'x; cap_addr = 'x;
    cap_wb_en = 'x; cap_wb_data = 'x; cap_addr_exc = 'x; cap_bus_err = 'x;
    cap_req = 0; cap_stall = 0; cap_done_cyc = 0;
    @(posedge clk); #1;
    valid = 1'b1; instr_op = op; mem_addr = addr; mem_sel = sel;
    byte_off = off; rt_value = rt; bad_addr = bad;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stall) cap_stall++;
      if (bus_if.req) begin
        if (cap_req == 0) begin
          cap_we = {31'd0, bus_if.we}; cap_sel = {28'd0, bus_if.sel};
          cap_wdata = bus_if.wdata; cap_addr = bus_if.addr;
        end
        cap_req++;
        if (ack_delay >= 0 && cap_req > ack_delay) begin
          bus_if.ack = 1'b1; bus_if.rdata = rdata; llbit_clear = clr_at_ack;
        end
      end
      if (done) begin
        cap_done_cyc = cyc;
        cap_wb_en = {31'd0, wb_en}; cap_wb_data = wb_data;
        cap_addr_exc = {31'd0, addr_exc}; cap_bus_err = {31'd0, bus_err};
        fin = 1'b1;
        valid = 1'b0; bus_if.ack = 1'b0; llbit_clear = 1'b0; bad_addr = 1'b0;
      end
    end
    check("done_reached", {31'd0, fin}, 32'd1);
    bus_if.ack = 1'b0;
    @(negedge clk);
    cap_done_after = {31'd0, done};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; instr_op = '0; mem_addr = '0; mem_sel = '0;
    bad_addr = 1'b0; byte_off = '0; rt_value = '0; llbit_clear = 1'b0;
    bus_if.ack = 1'b0; bus_if.rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, bus_if.req}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wdata", bus_if.wdata, 0);
    check("rst_stall", {31'd0, stall}, 0);
    rst_n = 1'b1;

    // LB offset 3, sign-extended, ack with first request cycle
    run_op(OP_LB, 32'h0000_0100, 4'b0001, 2'd3, 32'h0, 1'b0, 0, 32'h1122_3380, 1'b0);
    check("lb_sel", cap_sel, 32'h1);
    check("lb_we", cap_we, 0);
    check("lb_addr", cap_addr, 32'h0000_0100);
    check("lb_done_cyc", cap_done_cyc, 3);
    check("lb_stall", cap_stall, 2);
    check("lb_wb_en", cap_wb_en, 1);
    check("lb_wb_data", cap_wb_data, 32'hffff_ff80);
    check("lb_done_pulse", cap_done_after, 0);

    // SWL offset 1, ack one cycle late
    run_op(OP_SWL, 32'h0000_0200, 4'b0111, 2'd1, 32'haabb_ccdd, 1'b0, 1, 32'h0, 1'b0);
    check("swl_we", cap_we, 1);
    check("swl_sel", cap_sel, 32'h7);
    check("swl_wdata", cap_wdata, 32'h00aa_bbcc);
    check("swl_req_cycles", cap_req, 2);
    check("swl_done_cyc", cap_done_cyc, 4);
    check("swl_wb_en", cap_wb_en, 0);

    run_op(OP_LWR, 32'h0000_0300, 4'b1100, 2'd1, 32'haabb_ccdd, 1'b0, 0, 32'h1122_3344, 1'b0);
    check("lwr_wb_data", cap_wb_data, 32'haabb_1122);
    run_op(OP_LWL, 32'h0000_0300, 4'b0011, 2'd2, 32'haabb_ccdd, 1'b0, 0, 32'h1122_3344, 1'b0);
    check("lwl_wb_data", cap_wb_data, 32'h3344_ccdd);
    run_op(OP_LH, 32'h0000_0400, 4'b0011, 2'd2, 32'h0, 1'b0, 0, 32'h1234_8001, 1'b0);
    check("lh_wb_data", cap_wb_data, 32'hffff_8001);
    run_op(OP_LHU, 32'h0000_0400, 4'b1100, 2'd0, 32'h0, 1'b0, 0, 32'h8001_1234, 1'b0);
    check("lhu_wb_data", cap_wb_data, 32'h0000_8001);
    run_op(OP_LBU, 32'h0000_0400, 4'b1000, 2'd0, 32'h0, 1'b0, 2, 32'ha5ff_ffff, 1'b0);
    check("lbu_wb_data", cap_wb_data, 32'h0000_00a5);
    run_op(OP_SB, 32'h0000_0500, 4'b1000, 2'd0, 32'h1234_56ee, 1'b0, 0, 32'h0, 1'b0);
    check("sb_wdata", cap_wdata, 32'heeee_eeee);
    run_op(OP_SH, 32'h0000_0500, 4'b0011, 2'd2, 32'h1234_beef, 1'b0, 0, 32'h0, 1'b0);
    check("sh_wdata", cap_wdata, 32'hbeef_beef);
    run_op(OP_SWR, 32'h0000_0500, 4'b1100, 2'd1, 32'haabb_ccdd, 1'b0, 0, 32'h0, 1'b0);
    check("swr_wdata", cap_wdata, 32'hccdd_0000);

    // LL then SC succeeds, second SC fails without touching the bus
    run_op(OP_LL, 32'h0000_0600, 4'b1111, 2'd0, 32'h0, 1'b0, 0, 32'hdead_beef, 1'b0);
    check("ll_wb_data", cap_wb_data, 32'hdead_beef);
    run_op(OP_SC, 32'h0000_0600, 4'b1111, 2'd0, 32'h1234_5678, 1'b0, 0, 32'h0, 1'b0);
    check("sc1_req_cycles", cap_req, 1);
    check("sc1_wdata", cap_wdata, 32'h1234_5678);
    check("sc1_wb_en", cap_wb_en, 1);
    check("sc1_wb_data", cap_wb_data, 1);
    run_op(OP_SC, 32'h0000_0600, 4'b1111, 2'd0, 32'h1234_5678, 1'b0, 0, 32'h0, 1'b0);
    check("sc2_req_cycles", cap_req, 0);
    check("sc2_done_cyc", cap_done_cyc, 2);
    check("sc2_wb_en", cap_wb_en, 1);
    check("sc2_wb_data", cap_wb_data, 0);

    // Link clear coincident with LL ack wins, so the following SC fails
    run_op(OP_LL, 32'h0000_0700, 4'b1111, 2'd0, 32'h0, 1'b0, 0, 32'h0bad_f00d, 1'b1);
    run_op(OP_SC, 32'h0000_0700, 4'b1111, 2'd0, 32'h1, 1'b0, 0, 32'h0, 1'b0);
    check("sc_clr_req_cycles", cap_req, 0);
    check("sc_clr_wb_data", cap_wb_data, 0);

    // Non-memory opcode: no stall, no bus activity
    @(posedge clk); #1;
    valid = 1'b1; instr_op = 6'h00;
    @(negedge clk);
    check("nonmem_stall", {31'd0, stall}, 0);
    @(negedge clk);
    check("nonmem_req", {31'd0, bus_if.req}, 0);
    valid = 1'b0;

    // Misaligned LW: address error, one stall cycle, no bus request
    run_op(OP_LW, 32'h0000_0800, 4'b1111, 2'd1, 32'h0, 1'b1, 0, 32'h0, 1'b0);
    check("bad_req_cycles", cap_req, 0);
    check("bad_addr_exc", cap_addr_exc, 1);
    check("bad_stall", cap_stall, 1);
    check("bad_done_cyc", cap_done_cyc, 2);
    check("bad_wb_en", cap_wb_en, 0);

    // Ack withheld: timeout after 4 request cycles
    run_op(OP_LW, 32'h0000_0900, 4'b1111, 2'd0, 32'h0, 1'b0, -1, 32'h0, 1'b0);
    check("tmo_req_cycles", cap_req, 4);
    check("tmo_bus_err", cap_bus_err, 1);
    check("tmo_done_cyc", cap_done_cyc, 6);
    check("tmo_wb_en", cap_wb_en, 0);

    // Reset while BUSY clears every output and suppresses completion
    @(posedge clk); #1;
    valid = 1'b1; instr_op = OP_LW; mem_addr = 32'h0000_0a00; mem_sel = 4'b1111;
    byte_off = 2'd0; bad_addr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rbusy_req_before", {31'd0, bus_if.req}, 1);
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("rbusy_req", {31'd0, bus_if.req}, 0);
    check("rbusy_addr", bus_if.addr, 0);
    check("rbusy_sel", {28'd0, bus_if.sel}, 0);
    check("rbusy_wb_data", wb_data, 0);
    check("rbusy_done", {31'd0, done}, 0);
    check("rbusy_stall", {31'd0, stall}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rbusy_no_done", {31'd0, done}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
